replacement_engine: RTL and testbench
=====================================

# replacement_engine

Parametrised victim-selection engine for the iob-cache tag/valid stage, succeeding the combinational per-set policy block. It owns the per-set replacement state internally and offers selectable policies: LRU, PLRU_mru, PLRU_tree, and a new LFSR random policy. Beyond that, it adds invalid-way-first selection, per-way lock masking and a sequential set-initialisation sweep. Victims are returned through a registered one-cycle request/acknowledge handshake; hit/fill updates arrive on a separate port.

## Interface
- N_WAYS, 8: associativity; power of 2, 2..16
- LINE_OFF_W, 7: set index width; DEPTH = 2**LINE_OFF_W sets
- NWAY_W, $clog2(N_WAYS): way index width
- REP_POLICY, 3: 0 LRU, 1 PLRU_mru, 3 PLRU_tree, 4 RANDOM
- LFSR_SEED, 16'hACE1: random-policy LFSR reset value; must be nonzero
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- init_req  in  1  pulse; start state-init sweep of all sets
- busy  out  1  high while sweep in progress
- sel_req  in  1  request victim for sel_addr
- sel_addr  in  LINE_OFF_W  set index of request
- valid_ways  in  N_WAYS  valid bits of the set, sampled with sel_req
- lock_ways  in  N_WAYS  ways excluded from replacement, sampled with sel_req
- sel_ack  out  1  one-cycle pulse; victim outputs valid
- way_select  out  N_WAYS  one-hot victim
- way_select_bin  out  NWAY_W  binary victim
- all_locked  out  1  with sel_ack: no replaceable way exists
- upd_en  in  1  record access (hit or fill)
- upd_addr  in  LINE_OFF_W  set index of update
- upd_way  in  N_WAYS  one-hot accessed way

## Operation
- State array: DEPTH entries, held in flops and cleared by reset.
  - Entry width: LRU N_WAYS*NWAY_W (rank per way); PLRU_mru N_WAYS; PLRU_tree N_WAYS-1; RANDOM none.
- Reset/init entry value:
  - LRU: way i has rank i, so way 0 is LRU.
  - PLRU_mru and PLRU_tree: all zeros.
- FSM has two states, IDLE and INIT.
  - IDLE→INIT on init_req; INIT writes the reset value to set cnt, with cnt running 0..DEPTH-1 at one set per cycle.
  - INIT→IDLE after cnt=DEPTH-1; cnt wraps to 0.
- While busy: sel_req gets no ack, upd_en is ignored, init_req is ignored.
- init_req and sel_req in the same IDLE cycle: init wins and the request is dropped.
- Victim priority, with candidates = ~lock_ways:
  - 1) The lowest-index way that is both invalid and a candidate.
  - 2) Otherwise the policy victim among candidates, as follows.
    - LRU: candidate with the lowest rank.
    - PLRU_mru: lowest-index candidate with mru bit 0; otherwise the lowest-index candidate.
    - PLRU_tree: the tree-traversed way (node 0 goes left, node 1 goes right) if it is a candidate; otherwise the lowest-index candidate.
    - RANDOM: LFSR[NWAY_W-1:0]; if that way is locked, the next candidate upward with wrap.
  - 3) No candidates: all_locked=1, way_select=0, way_select_bin=0.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle out of reset.
- Update applies when upd_en is set and upd_way is exactly one-hot; zero or multi-hot upd_way writes nothing.
  - LRU: hit way rank becomes N_WAYS-1; ways with rank greater than the hit way's old rank decrement; other ranks are unchanged.
  - PLRU_mru: set the hit bit; if the result is all ones, store only the hit bit.
  - PLRU_tree: every node on the hit way's path points away from it; other nodes are unchanged.
  - RANDOM: no state change.
- sel and upd in the same cycle (same or different set): selection uses the pre-update state; the update commits at that edge.

## Timing
- Reset values: busy=0, sel_ack=0, way_select=0, way_select_bin=0, all_locked=0, FSM=IDLE, cnt=0, LFSR=LFSR_SEED, array at init values.
- Selection latency is 1 cycle: sel_req at edge N gives sel_ack plus registered outputs during cycle N+1. Outputs hold until the next ack.
- Back-to-back sel_req every cycle gives one ack per cycle.
- An update at edge N is visible to a sel_req sampled at edge N+1.
- Sweep: init_req at edge N sets busy=1 from N+1; busy stays high for exactly DEPTH cycles.
- Reset asserted mid-sweep aborts immediately: busy=0 and the array reaches init values asynchronously.

## Test plan
- LRU, N_WAYS=4: after reset, sel set 5 with all valid/unlocked → ack next cycle, way_select=4'b0001. Then upd way 0, sel → 4'b0010. Then upd ways 1,2,3, sel → 4'b0001.
- PLRU_tree, N_WAYS=8: upd set 0 with way 3, sel → way_select_bin=4. Repeat with lock_ways=8'h10 → bin=0.
- Invalid-first: valid_ways=8'hF7 → bin=3 under every policy; lock_ways=8'h08 as well → policy victim.
- All locked: lock_ways=8'hFF → sel_ack=1, all_locked=1, way_select=0.
- Init sweep, LINE_OFF_W=3: modify sets 0 and 7, pulse init_req → busy high exactly 8 cycles, sel_req during busy gets no ack. Afterwards both sets return the reset victim (way 0).
- Simultaneous: sel_req and upd_en to the same set, same cycle → ack reflects the old state; the next sel reflects the update. Multi-hot upd_way → state unchanged.

Source files
------------

// File: rtl/replacement_engine.sv
// replacement_engine: per-set victim selection (LRU, PLRU_mru, PLRU_tree, random) with invalid-first, lock masking and init sweep
module replacement_engine #(
  parameter int N_WAYS = 8,
  parameter int LINE_OFF_W = 7,
  parameter int NWAY_W = $clog2(N_WAYS),
  parameter int REP_POLICY = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  sel_req,
  input  logic [LINE_OFF_W-1:0] sel_addr,
  input  logic [N_WAYS-1:0]     valid_ways,
  input  logic [N_WAYS-1:0]     lock_ways,
  output logic                  sel_ack,
  output logic [N_WAYS-1:0]     way_select,
  output logic [NWAY_W-1:0]     way_select_bin,
  output logic                  all_locked,
  input  logic                  upd_en,
  input  logic [LINE_OFF_W-1:0] upd_addr,
  input  logic [N_WAYS-1:0]     upd_way
);
  localparam int DEPTH = 2 ** LINE_OFF_W;
  localparam int WW = N_WAYS * NWAY_W;
  localparam int EW = REP_POLICY == 0 ? WW : REP_POLICY == 1 ? N_WAYS : REP_POLICY == 3 ? N_WAYS - 1 : 1;

  // Entries are handled at the widest (LRU) width internally and truncated on store.
  function automatic logic [WW-1:0] init_val();
    logic [WW-1:0] v;
    v = '0;
    if (REP_POLICY == 0)
      for (int i = 0; i < N_WAYS; i++) v[i*NWAY_W +: NWAY_W] = NWAY_W'(i);
    return v;
  endfunction

  localparam logic [WW-1:0] RST_W = init_val();
  localparam logic [EW-1:0] RST_VAL = RST_W[EW-1:0];

  function automatic logic [NWAY_W-1:0] lowest(input logic [N_WAYS-1:0] m);
    logic [NWAY_W-1:0] v;
    v = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) if (m[i]) v = NWAY_W'(i);
    return v;
  endfunction

  function automatic logic [NWAY_W-1:0] lru_victim(input logic [WW-1:0] s, input logic [N_WAYS-1:0] c);
    logic [NWAY_W-1:0] best, v;
    logic found;
    best = '1;
    v = '0;
    found = 1'b0;
    for (int i = 0; i < N_WAYS; i++)
      if (c[i] && (!found || s[i*NWAY_W +: NWAY_W] < best)) begin
        best = s[i*NWAY_W +: NWAY_W];
        v = NWAY_W'(i);
        found = 1'b1;
      end
    return v;
  endfunction

  function automatic logic [NWAY_W-1:0] mru_victim(input logic [WW-1:0] s, input logic [N_WAYS-1:0] c);
    logic [N_WAYS-1:0] z;
    z = c & ~s[N_WAYS-1:0];
    return |z ? lowest(z) : lowest(c);
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
  function automatic logic [NWAY_W-1:0] tree_victim(input logic [WW-1:0] s, input logic [N_WAYS-1:0] c);
    int n;
    logic [NWAY_W-1:0] t;
    n = 0;
    for (int l = 0; l < NWAY_W; l++) n = 2 * n + 1 + int'(s[n]);
    t = NWAY_W'(n - (N_WAYS - 1));
    return c[t] ? t : lowest(c);
  endfunction

  function automatic logic [NWAY_W-1:0] rnd_victim(input logic [NWAY_W-1:0] r, input logic [N_WAYS-1:0] c);
    logic [NWAY_W-1:0] v, idx;
    logic found;
    v = r;
    found = c[r];
    for (int k = 1; k < N_WAYS; k++) begin
      idx = r + NWAY_W'(k);
      if (!found && c[idx]) begin
        v = idx;
        found = 1'b1;
      end
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] lru_next(input logic [WW-1:0] s, input logic [NWAY_W-1:0] w);
    logic [WW-1:0] v;
    logic [NWAY_W-1:0] o, r;
    o = s[w*NWAY_W +: NWAY_W];
    v = s;
    for (int i = 0; i < N_WAYS; i++) begin
      r = s[i*NWAY_W +: NWAY_W];
      v[i*NWAY_W +: NWAY_W] = NWAY_W'(i) == w ? NWAY_W'(N_WAYS - 1) : r > o ? r - NWAY_W'(1) : r;
    end
    return v;
  endfunction

  function automatic logic [WW-1:0] mru_next(input logic [WW-1:0] s, input logic [N_WAYS-1:0] oh);
    logic [N_WAYS-1:0] m;
    m = s[N_WAYS-1:0] | oh;
    return WW'(&m ? oh : m);
  endfunction

  function automatic logic [WW-1:0] tree_next(input logic [WW-1:0] s, input logic [NWAY_W-1:0] w);
    logic [WW-1:0] t;
    logic b;
    int n;
    t = s;
    n = 0;
    for (int l = 0; l < NWAY_W; l++) begin
      b = w[NWAY_W-1-l];
      t[n] = ~b;
      n = 2 * n + 1 + int'(b);
    end
    return t;
  endfunction

  typedef enum logic {IDLE, INIT} state_t;

  state_t state;
  logic [LINE_OFF_W-1:0] cnt;
  logic [15:0] lfsr;
  logic [EW-1:0] st [DEPTH];
  logic [WW-1:0] cur, old, nxt;
  logic [N_WAYS-1:0] cand, inv;
  logic [NWAY_W-1:0] pv, vb, uw;
  logic al, upd_ok;

  always_comb begin
    cur = WW'(st[sel_addr]);
    old = WW'(st[upd_addr]);
    cand = ~lock_ways;
    inv = cand & ~valid_ways;
    pv = REP_POLICY == 0 ? lru_victim(cur, cand) :
         REP_POLICY == 1 ? mru_victim(cur, cand) :
         REP_POLICY == 3 ? tree_victim(cur, cand) : rnd_victim(lfsr[NWAY_W-1:0], cand);
    vb = |inv ? lowest(inv) : pv;
    al = ~|cand;
    uw = lowest(upd_way);
    upd_ok = upd_en && $onehot(upd_way);
    nxt = REP_POLICY == 0 ? lru_next(old, uw) :
          REP_POLICY == 1 ? mru_next(old, upd_way) :
          REP_POLICY == 3 ? tree_next(old, uw) : old;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      busy <= 1'b0;
      sel_ack <= 1'b0;
      way_select <= '0;
      way_select_bin <= '0;
      all_locked <= 1'b0;
      lfsr <= LFSR_SEED;
      for (int i = 0; i < DEPTH; i++) st[i] <= RST_VAL;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      sel_ack <= 1'b0;
      if (state == IDLE) begin
        if (upd_ok) st[upd_addr] <= nxt[EW-1:0];
        if (init_req) begin
          state <= INIT;
          busy <= 1'b1;
        end else if (sel_req) begin
          sel_ack <= 1'b1;
          all_locked <= al;
          way_select_bin <= al ? '0 : vb;
          way_select <= al ? '0 : N_WAYS'(1) << vb;
        end
      end else begin
        st[cnt] <= RST_VAL;
        cnt <= cnt + LINE_OFF_W'(1);
        if (cnt == LINE_OFF_W'(DEPTH - 1)) begin
          state <= IDLE;
          busy <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_replacement_engine.sv
// tb_replacement_engine: directed vectors across LRU(4-way), PLRU_mru, PLRU_tree and random instances
module tb_replacement_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_req = 1'b0;
  logic [3:0] sel, upd;
  logic [2:0] sa, ua;
  logic [7:0] valid, lock, uw;
  logic [3:0] ack, busy, al;
  logic [3:0] ws0;
  logic [7:0] ws1, ws2, ws3;
  logic [1:0] bin0;
  logic [2:0] bin1, bin2, bin3;
  logic [3:0][7:0] ws;
  logic [3:0][3:0] bin;
  logic [15:0] m;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign ws[0] = {4'h0, ws0};
  assign ws[1] = ws1;
  assign ws[2] = ws2;
  assign ws[3] = ws3;
  assign bin[0] = {2'b0, bin0};
  assign bin[1] = {1'b0, bin1};
  assign bin[2] = {1'b0, bin2};
  assign bin[3] = {1'b0, bin3};

  replacement_engine #(.N_WAYS(4), .LINE_OFF_W(3), .REP_POLICY(0)) u_lru (
    .clk(clk), .reset(rst_n), .init_req(init_req), .busy(busy[0]), .sel_req(sel[0]), .sel_addr(sa),
    .valid_ways(valid[3:0]), .lock_ways(lock[3:0]), .sel_ack(ack[0]), .way_select(ws0), .way_select_bin(bin0),
    .all_locked(al[0]), .upd_en(upd[0]), .upd_addr(ua), .upd_way(uw[3:0]));
  replacement_engine #(.N_WAYS(8), .LINE_OFF_W(3), .REP_POLICY(1)) u_mru (
    .clk(clk), .reset(rst_n), .init_req(init_req), .busy(busy[1]), .sel_req(sel[1]), .sel_addr(sa),
    .valid_ways(valid), .lock_ways(lock), .sel_ack(ack[1]), .way_select(ws1), .way_select_bin(bin1),
    .all_locked(al[1]), .upd_en(upd[1]), .upd_addr(ua), .upd_way(uw));
  replacement_engine #(.N_WAYS(8), .LINE_OFF_W(3), .REP_POLICY(3)) u_tree (
    .clk(clk), .reset(rst_n), .init_req(init_req), .busy(busy[2]), .sel_req(sel[2]), .sel_addr(sa),
    .valid_ways(valid), .lock_ways(lock), .sel_ack(ack[2]), .way_select(ws2), .way_select_bin(bin2),
    .all_locked(al[2]), .upd_en(upd[2]), .upd_addr(ua), .upd_way(uw));
  replacement_engine #(.N_WAYS(8), .LINE_OFF_W(3), .REP_POLICY(4)) u_rnd (
    .clk(clk), .reset(rst_n), .init_req(init_req), .busy(busy[3]), .sel_req(sel[3]), .sel_addr(sa),
    .valid_ways(valid), .lock_ways(lock), .sel_ack(ack[3]), .way_select(ws3), .way_select_bin(bin3),
    .all_locked(al[3]), .upd_en(upd[3]), .upd_addr(ua), .upd_way(uw));

  // Reference Galois LFSR, x^16+x^14+x^13+x^11+1, seed ACE1
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= 16'hACE1;
    else m <= {1'b0, m[15:1]} ^ (m[0] ? 16'hB400 : 16'h0000);

  typedef struct {
    int d;
    bit s;
    bit u;
    logic [2:0] a;
    logic [7:0] v;
    logic [7:0] l;
    logic [7:0] w;
    int eb;
    bit eal;
  } vec_t;

  vec_t tab[$];
  int last[4] = '{0, 0, 0, 0};

  function automatic vec_t mk(int d, bit s, bit u, int a, int v, int l, int w, int eb, bit eal);
    vec_t t;
    t.d = d; t.s = s; t.u = u; t.a = 3'(a); t.v = 8'(v); t.l = 8'(l); t.w = 8'(w); t.eb = eb; t.eal = eal;
    return t;
  endfunction

  function automatic void vs(int d, int a, int v, int l, int eb, bit eal);
    tab.push_back(mk(d, 1'b1, 1'b0, a, v, l, 0, eb, eal));
  endfunction

  function automatic void vu(int d, int a, int w);
    tab.push_back(mk(d, 1'b0, 1'b1, a, 8'hFF, 0, w, 0, 1'b0));
  endfunction

  function automatic void vb(int d, int a, int w, int eb);
    tab.push_back(mk(d, 1'b1, 1'b1, a, 8'hFF, 0, w, eb, 1'b0));
  endfunction

  function automatic int rnd_exp(logic [15:0] r, logic [7:0] l);
    int b;
    b = int'(r[2:0]);
    for (int k = 0; k < 8; k++) if (!l[(b + k) % 8]) return (b + k) % 8;
    return 0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sel_chk(int d, int a, int eb, string nm);
    sel = 4'(1 << d); sa = 3'(a); valid = 8'hFF; lock = 8'h00;
    @(negedge clk);
    sel = 4'h0;
    chk(nm, {ack[d], al[d], bin[d]}, {1'b1, 1'b0, 4'(eb)});
  endtask

  task automatic do_upd(int d, int a, int w);
    upd = 4'(1 << d); ua = 3'(a); uw = 8'(w);
    @(negedge clk);
    upd = 4'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int e, nb;
    logic seen;
    vec_t t;
    sel = '0; upd = '0; sa = '0; ua = '0; valid = 8'hFF; lock = '0; uw = '0;
    // LRU, 4 ways, set 5
    vs(0, 5, 'hFF, 0, 0, 0);  vu(0, 5, 'h01);  vs(0, 5, 'hFF, 0, 1, 0);
    vu(0, 5, 'h02);  vu(0, 5, 'h04);  vu(0, 5, 'h08);  vs(0, 5, 'hFF, 0, 0, 0);
    vs(0, 5, 'hFF, 'h01, 1, 0);  vs(0, 5, 'hF7, 0, 3, 0);  vs(0, 5, 'hF7, 'h08, 0, 0);
    vs(0, 5, 'hFF, 'hFF, 0, 1);  vb(0, 5, 'h01, 0);  vs(0, 5, 'hFF, 0, 1, 0);
    vu(0, 5, 'h03);  vs(0, 5, 'hFF, 0, 1, 0);  vu(0, 5, 'h00);  vs(0, 5, 'hFF, 0, 1, 0);
    vs(0, 2, 'hFF, 0, 0, 0);
    // PLRU_mru, set 3
    vs(1, 3, 'hFF, 0, 0, 0);  vu(1, 3, 'h01);  vs(1, 3, 'hFF, 0, 1, 0);  vs(1, 3, 'hFF, 'h02, 2, 0);
    vs(1, 3, 'hF7, 0, 3, 0);  vs(1, 3, 'hF7, 'h08, 1, 0);
    for (int i = 1; i < 7; i++) vu(1, 3, 1 << i);
    vs(1, 3, 'hFF, 0, 7, 0);  vs(1, 3, 'hFF, 'h80, 0, 0);  vu(1, 3, 'h30);  vs(1, 3, 'hFF, 0, 7, 0);
    vu(1, 3, 'h80);  vs(1, 3, 'hFF, 0, 0, 0);  vs(1, 3, 'hFF, 'h01, 1, 0);
    // PLRU_tree, set 0
    vs(2, 0, 'hFF, 0, 0, 0);  vu(2, 0, 'h08);  vs(2, 0, 'hFF, 0, 4, 0);  vs(2, 0, 'hFF, 'h10, 0, 0);
    vs(2, 0, 'hF7, 0, 3, 0);  vs(2, 0, 'hF7, 'h08, 4, 0);  vs(2, 0, 'hFF, 'hFF, 0, 1);
    vu(2, 0, 'h01);  vu(2, 0, 'h10);  vs(2, 0, 'hFF, 0, 2, 0);  vb(2, 0, 'h04, 2);  vs(2, 0, 'hFF, 0, 6, 0);
    // RANDOM; eb = -1 means derive from the reference LFSR
    vs(3, 1, 'hF7, 0, 3, 0);  vs(3, 1, 'hFF, 'hFE, 0, 0);  vs(3, 1, 'hFF, 'h7F, 7, 0);
    vs(3, 1, 'hFF, 'hFF, 0, 1);  vs(3, 1, 'hFF, 0, -1, 0);  vs(3, 1, 'hFF, 'h55, -1, 0);
    vs(3, 1, 'hF7, 'h08, -1, 0);  vs(3, 1, 'hFF, 0, -1, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      chk($sformatf("reset_state%0d", d), {busy[d], ack[d], al[d], ws[d], bin[d]}, 32'h0);

    foreach (tab[i]) begin
      t = tab[i];
      sel = t.s ? 4'(1 << t.d) : 4'h0;
      upd = t.u ? 4'(1 << t.d) : 4'h0;
      sa = t.a; ua = t.a; valid = t.v; lock = t.l; uw = t.w;
      e = t.eb < 0 ? rnd_exp(m, t.l) : t.eb;
      @(negedge clk);
      if (t.s) begin
        chk($sformatf("vec%0d_dut%0d", i, t.d), {ack[t.d], al[t.d], ws[t.d], bin[t.d]},
            {1'b1, t.eal, t.eal ? 8'h00 : 8'(1 << e), t.eal ? 4'h0 : 4'(e)});
        last[t.d] = t.eal ? 0 : e;
      end else
        chk($sformatf("vec%0d_hold%0d", i, t.d), {ack[t.d], bin[t.d]}, {1'b0, 4'(last[t.d])});
    end
    sel = '0; upd = '0; valid = 8'hFF; lock = '0;

    // Modify sets 0 and 7, then sweep
    do_upd(0, 0, 'h01);
    do_upd(0, 7, 'h01);
    do_upd(2, 7, 'h08);
    sel_chk(0, 7, 1, "pre_sweep_lru7");
    sel_chk(2, 7, 4, "pre_sweep_tree7");
    init_req = 1'b1; sel = 4'b0001; sa = 3'd0;
    @(negedge clk);
    init_req = 1'b0;
    nb = 0;
    seen = 1'b0;
    for (int k = 0; k < 20 && busy[0]; k++) begin
      seen |= ack[0];
      nb++;
      @(negedge clk);
    end
    seen |= ack[0];
    sel = 4'h0;
    chk("sweep_busy_cycles", nb, 8);
    chk("sweep_no_ack", seen, 0);
    sel_chk(0, 0, 0, "post_sweep_lru0");
    sel_chk(0, 7, 0, "post_sweep_lru7");
    sel_chk(0, 5, 0, "post_sweep_lru5");
    sel_chk(2, 0, 0, "post_sweep_tree0");
    sel_chk(2, 7, 0, "post_sweep_tree7");

    // Reset in the middle of a sweep
    do_upd(0, 7, 'h01);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_sweep_busy", busy[0], 1);
    #2 rst_n = 1'b0;
    #1 chk("abort_busy", {busy[0], busy[2]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sel_chk(0, 7, 0, "abort_lru7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
